program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Writer side of the instruction memory: receives a byte stream from the host link (UART receiver) and assembles big-endian 32-bit MIPS instructions.
- Writes each word to program memory at consecutive word addresses, starting at 0.
- Holds the CPU in load mode (`loading`) until a halt word arrives or memory is full, then signals completion.

Parameters:
- ADDR_W, 11, word-address width; memory depth is 2**ADDR_W words.
- HALT_WORD, 32'hFFFF_FFFF, terminator instruction; it is written to memory, then loading ends.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a load from address 0.
- rx_data  in  8  received byte.
- rx_valid  in  1  rx_data valid; the byte is consumed when rx_valid && rx_ready.
- rx_ready  out  1  loader accepts a byte this cycle.
- wr_en  out  1  one-cycle program-memory write strobe.
- wr_addr  out  ADDR_W  word address of the write.
- wr_data  out  32  instruction word.
- loading  out  1  high while a load is in progress; CPU stalled/held.
- done  out  1  high after a load ends; cleared by the next start.
- overflow  out  1  load ended because memory filled without a halt word.
- word_count  out  ADDR_W+1  number of words written in the current/last load.
- chk_err  out  1  checksum mismatch; CHECKSUM_EN only, tied 0 otherwise.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; byte counter, address and word_count cleared.
  - Async assert, sync deassert is handled upstream.
  - Reset mid-load discards any partial word; memory contents are not cleared.
- FSM states: IDLE, RECV, WRITE, CHECK (CHECKSUM_EN only), DONE.
- IDLE/DONE:
  - rx_ready=0.
  - start -> RECV; clears byte index, address, word_count, done, overflow, chk_err; sets loading=1.
  - start in RECV/WRITE/CHECK is ignored.
- RECV:
  - rx_ready=1.
  - Each accepted byte shifts into a 32-bit assembly register, MSB first: byte0 -> [31:24] ... byte3 -> [7:0].
  - When the 4th byte is accepted -> WRITE next cycle.
  - Gaps in rx_valid are permitted indefinitely.
- WRITE: exactly one cycle.
  - rx_ready=0, wr_en=1, wr_addr=current address, wr_data=assembled word.
  - word_count increments in the same cycle.
  - If word==HALT_WORD -> CHECK if CHECKSUM_EN, else DONE.
  - Else if wr_addr == 2**ADDR_W-1 -> DONE with overflow=1.
  - Else address+1 -> RECV.
- Latency: wr_en asserts the cycle after the 4th byte handshake.
- Throughput: at most 1 byte/cycle; 5 cycles/word minimum.
- DONE: loading=0, done=1; all other outputs hold their values.
- Halt word at the last address: halt has priority, so overflow=0.
- wr_addr and wr_data hold their last values when wr_en=0.

Optional Feature:
- Macro: PROGRAM_LOADER_CHECKSUM_EN.
- With the macro:
  - A running 8-bit XOR is kept over every accepted payload byte, including the halt word.
  - After the halt WRITE, the FSM enters CHECK with rx_ready=1 and accepts one more byte.
  - chk_err = (byte != running XOR); then -> DONE.
  - The checksum clears on start.
  - The overflow path skips CHECK.
- Without the macro: no CHECK state, no checksum register, chk_err constant 0.

Decomposition:
- Shared package (mips_pkg):
  - FSM state encoding typedef.
  - HALT_WORD default constant.
  - PROG_ADDR_W = 11.
- One natural sub-module, word_assembler: shift register plus 2-bit byte index, with a word_ready pulse output.
- The FSM, address counter and checksum stay in program_loader.

Test Plan:
- start; send bytes 20 08 00 05, 20 09 00 07, FF FF FF FF back-to-back:
  - wr_en at addr 0 = 0x20080005, addr 1 = 0x20090007, addr 2 = 0xFFFFFFFF.
  - done=1, word_count=3, overflow=0, loading low after the last write.
- Same stream with random 0-5 cycle rx_valid gaps -> identical writes; rx_ready=0 during every WRITE cycle.
- ADDR_W=2; send 4 non-halt words -> writes at addrs 0..3, overflow=1, done=1, further bytes not accepted (rx_ready=0).
- Assert rst_n=0 after 2 bytes of word 1:
  - All outputs 0 immediately.
  - A new start plus a full stream writes from addr 0 with no stale bytes.
- Pulse start while in RECV mid-word -> ignored; the word completes normally.
- CHECKSUM_EN: stream 01 02 03 04 FF FF FF FF plus checksum 04 -> chk_err=0; checksum 05 -> chk_err=1; done=1 in both cases.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-memory loader: state encoding and defaults.
// The CHECK state exists only when PROGRAM_LOADER_CHECKSUM_EN is defined.
package mips_pkg;

  localparam int unsigned PROG_ADDR_W       = 11;
  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    StIdle,
    StRecv,
    StWrite,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    StCheck,
`endif
    StDone
  } loader_state_e;

endpackage

// File: rtl/word_assembler.sv
// Packs a byte stream MSB-first into 32-bit words; word_ready marks the 4th accepted byte.
// word holds the last completed word until the next one completes.
module word_assembler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_ready
);

  logic [1:0]  idx_q;
  logic [23:0] shift_q;
  logic [31:0] word_q;

  assign word_ready = byte_valid && (idx_q == 2'd3);
  assign word       = word_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= 2'd0;
      shift_q <= 24'd0;
      word_q  <= 32'd0;
    end else if (clear) begin
      idx_q <= 2'd0;
    end else if (byte_valid) begin
      shift_q <= {shift_q[15:0], byte_in};
      idx_q   <= idx_q + 2'd1;
      if (idx_q == 2'd3) begin
        word_q <= {shift_q, byte_in};
      end
    end
  end

endmodule

// File: rtl/program_loader.sv
// Loads a host byte stream into program memory as big-endian words, holding the CPU meanwhile.
// Optional trailing XOR checksum byte: define PROGRAM_LOADER_CHECKSUM_EN.
module program_loader
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W    = PROG_ADDR_W,
  parameter logic [31:0] HALT_WORD = HALT_WORD_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              loading,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W:0]   word_count,
  output logic              chk_err
);

  loader_state_e     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, wr_addr_q;
  logic [ADDR_W:0]   count_q;
  logic              loading_q, done_q, overflow_q;
  logic              start_ok, byte_valid, word_ready;

  assign start_ok   = start && ((state_q == StIdle) || (state_q == StDone));
  assign byte_valid = rx_valid && (state_q == StRecv);

  word_assembler u_asm (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (start_ok),
    .byte_valid (byte_valid),
    .byte_in    (rx_data),
    .word       (wr_data),
    .word_ready (word_ready)
  );

  always_comb begin
    state_d  = state_q;
    rx_ready = 1'b0;
    wr_en    = 1'b0;
    case (state_q)
      StIdle, StDone: begin
        if (start) state_d = StRecv;
      end
      StRecv: begin
        rx_ready = 1'b1;
        if (word_ready) state_d = StWrite;
      end
      StWrite: begin
        wr_en = 1'b1;
        if (wr_data == HALT_WORD) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          state_d = StCheck;
`else
          state_d = StDone;
`endif
        end else if (wr_addr_q == {ADDR_W{1'b1}}) begin
          state_d = StDone;
        end else begin
          state_d = StRecv;
        end
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      StCheck: begin
        rx_ready = 1'b1;
        if (rx_valid) state_d = StDone;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      wr_addr_q  <= '0;
      count_q    <= '0;
      loading_q  <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        addr_q     <= '0;
        count_q    <= '0;
        loading_q  <= 1'b1;
        done_q     <= 1'b0;
        overflow_q <= 1'b0;
      end
      // Latch the write address with the word so it holds after the write.
      if (word_ready) wr_addr_q <= addr_q;
      if (state_q == StWrite) begin
        count_q <= count_q + 1'b1;
        if (state_d == StRecv) addr_q <= addr_q + 1'b1;
        if (state_d == StDone) begin
          loading_q  <= 1'b0;
          done_q     <= 1'b1;
          overflow_q <= (wr_data != HALT_WORD);
        end
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      if (state_q == StCheck && rx_valid) begin
        loading_q <= 1'b0;
        done_q    <= 1'b1;
      end
`endif
    end
  end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0] xor_q;
  logic       chk_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xor_q     <= 8'd0;
      chk_err_q <= 1'b0;
    end else if (start_ok) begin
      xor_q     <= 8'd0;
      chk_err_q <= 1'b0;
    end else begin
      if (byte_valid) xor_q <= xor_q ^ rx_data;
      if (state_q == StCheck && rx_valid) chk_err_q <= (rx_data != xor_q);
    end
  end

  assign chk_err = chk_err_q;
`else
  assign chk_err = 1'b0;
`endif

  assign wr_addr    = wr_addr_q;
  assign word_count = count_q;
  assign loading    = loading_q;
  assign done       = done_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_program_loader.sv
// Randomized scoreboard bench for program_loader: full-size instance plus a 4-word instance.
module tb_program_loader;
  import mips_pkg::*;

  localparam int unsigned AW  = PROG_ADDR_W;
  localparam int unsigned SAW = 2;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic          start, rx_valid, rx_ready, wr_en, loading, done, overflow, chk_err;
  logic [7:0]    rx_data;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic [AW:0]   word_count;

  logic           s_start, s_rx_valid, s_rx_ready, s_wr_en, s_loading, s_done, s_overflow;
  logic           s_chk_err;
  logic [7:0]     s_rx_data;
  logic [SAW-1:0] s_wr_addr;
  logic [31:0]    s_wr_data;
  logic [SAW:0]   s_word_count;

  program_loader #(.ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .loading(loading), .done(done), .overflow(overflow), .word_count(word_count),
    .chk_err(chk_err)
  );

  program_loader #(.ADDR_W(SAW)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(s_start), .rx_data(s_rx_data), .rx_valid(s_rx_valid),
    .rx_ready(s_rx_ready), .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
    .loading(s_loading), .done(s_done), .overflow(s_overflow), .word_count(s_word_count),
    .chk_err(s_chk_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [10:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t exp_s_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Write monitors: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && wr_en) begin
      wr_t e;
      check("rx_ready during write", {63'd0, rx_ready}, 64'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected write: addr 0x%0h data 0x%0h, none expected", wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        check("write addr", {53'd0, wr_addr}, {53'd0, e.addr});
        check("write data", {32'd0, wr_data}, {32'd0, e.data});
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && s_wr_en) begin
      wr_t e;
      check("small rx_ready during write", {63'd0, s_rx_ready}, 64'd0);
      if (exp_s_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL small unexpected write: addr 0x%0h data 0x%0h, none expected",
                 s_wr_addr, s_wr_data);
      end else begin
        e = exp_s_q.pop_front();
        check("small write addr", {62'd0, s_wr_addr}, {53'd0, e.addr});
        check("small write data", {32'd0, s_wr_data}, {32'd0, e.data});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit sel, input logic v, input logic [7:0] d);
    if (sel) begin
      s_rx_valid = v;
      s_rx_data  = d;
    end else begin
      rx_valid = v;
      rx_data  = d;
    end
  endtask

  task automatic pulse_start(input bit sel);
    if (sel) s_start = 1'b1; else start = 1'b1;
    tick();
    s_start = 1'b0;
    start   = 1'b0;
  endtask

  task automatic send_byte(input bit sel, input logic [7:0] b, input int gap);
    int n = 0;
    drive(sel, 1'b0, 8'd0);
    repeat (gap) tick();
    drive(sel, 1'b1, b);
    while (!(sel ? s_rx_ready : rx_ready) && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL byte handshake timeout: rx_ready stayed 0, required 1");
    end
    tick();
    drive(sel, 1'b0, 8'd0);
  endtask

  task automatic wait_done(input bit sel);
    int n = 0;
    while (!(sel ? s_done : done) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL done timeout: done stayed 0, required 1");
    end
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    do w = $urandom; while (w == HALT_WORD_DEFAULT);
    return w;
  endfunction

  // Reference: words land at addresses 0,1,2..; stop after halt or after the last address.
  task automatic run_load(input bit sel, input logic [31:0] words[$], input int maxgap,
                          input bit bad_ck, input bit midstart);
    int          depth = sel ? (1 << SAW) : (1 << AW);
    int          cnt = 0;
    bit          ovf = 1'b0;
    bit          halted = 1'b0;
    logic [7:0]  x = 8'd0;
    logic [31:0] w;
    pulse_start(sel);
    foreach (words[i]) begin
      if (halted || ovf) break;
      w = words[i];
      if (sel) exp_s_q.push_back(wr_t'{addr: 11'(i), data: w});
      else     exp_q.push_back(wr_t'{addr: 11'(i), data: w});
      cnt++;
      for (int k = 0; k < 4; k++) begin
        logic [7:0] b;
        b = w[31-8*k -: 8];
        x ^= b;
        send_byte(sel, b, $urandom_range(0, maxgap));
        if (midstart && i == 0 && k == 1) pulse_start(sel);
      end
      if (w == HALT_WORD_DEFAULT) halted = 1'b1;
      else if (cnt == depth) ovf = 1'b1;
    end
    if (CK_EN && halted) send_byte(sel, x ^ {7'd0, bad_ck}, $urandom_range(0, maxgap));
    wait_done(sel);
    if (sel) begin
      check("small done", {63'd0, s_done}, 64'd1);
      check("small overflow", {63'd0, s_overflow}, {63'd0, ovf});
      check("small word_count", {61'd0, s_word_count}, 64'(cnt));
      check("small loading", {63'd0, s_loading}, 64'd0);
      check("small chk_err", {63'd0, s_chk_err}, {63'd0, CK_EN && halted && bad_ck});
      check("small pending writes", 64'(exp_s_q.size()), 64'd0);
    end else begin
      check("done", {63'd0, done}, 64'd1);
      check("overflow", {63'd0, overflow}, {63'd0, ovf});
      check("word_count", {52'd0, word_count}, 64'(cnt));
      check("loading", {63'd0, loading}, 64'd0);
      check("chk_err", {63'd0, chk_err}, {63'd0, CK_EN && halted && bad_ck});
      check("pending writes", 64'(exp_q.size()), 64'd0);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, " rx_ready"}, {63'd0, rx_ready}, 64'd0);
    check({tag, " wr_en"}, {63'd0, wr_en}, 64'd0);
    check({tag, " wr_addr"}, {53'd0, wr_addr}, 64'd0);
    check({tag, " wr_data"}, {32'd0, wr_data}, 64'd0);
    check({tag, " loading"}, {63'd0, loading}, 64'd0);
    check({tag, " done"}, {63'd0, done}, 64'd0);
    check({tag, " overflow"}, {63'd0, overflow}, 64'd0);
    check({tag, " word_count"}, {52'd0, word_count}, 64'd0);
    check({tag, " chk_err"}, {63'd0, chk_err}, 64'd0);
  endtask

  logic [31:0] base[$];
  logic [31:0] w[$];

  initial begin
    start = 1'b0; rx_valid = 1'b0; rx_data = 8'd0;
    s_start = 1'b0; s_rx_valid = 1'b0; s_rx_data = 8'd0;
    repeat (3) tick();
    check_zero("reset");
    check("small reset done", {63'd0, s_done}, 64'd0);
    check("small reset word_count", {61'd0, s_word_count}, 64'd0);
    rst_n = 1'b1;
    tick();

    base = {32'h2008_0005, 32'h2009_0007, HALT_WORD_DEFAULT};
    run_load(1'b0, base, 0, 1'b0, 1'b0);
    run_load(1'b0, base, 5, 1'b0, 1'b0);

    repeat (3) begin
      w = {};
      repeat ($urandom_range(1, 6)) w.push_back(rand_word());
      w.push_back(HALT_WORD_DEFAULT);
      run_load(1'b0, w, $urandom_range(0, 3), 1'b0, 1'b0);
    end

    // start pulsed mid-word must not disturb the load
    run_load(1'b0, base, 2, 1'b0, 1'b1);

    // Reset after two bytes of the second word
    pulse_start(1'b0);
    exp_q.push_back(wr_t'{addr: 11'd0, data: 32'h1122_3344});
    send_byte(1'b0, 8'h11, 0);
    send_byte(1'b0, 8'h22, 1);
    send_byte(1'b0, 8'h33, 0);
    send_byte(1'b0, 8'h44, 2);
    send_byte(1'b0, 8'h55, 1);
    send_byte(1'b0, 8'h66, 0);
    rst_n = 1'b0;
    #1;
    check_zero("mid-load reset");
    tick();
    rst_n = 1'b1;
    tick();
    run_load(1'b0, base, 1, 1'b0, 1'b0);

    // 4-word memory fills without a halt word
    w = {};
    repeat (6) w.push_back(rand_word());
    run_load(1'b1, w, 1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 8'hA5);
    for (int i = 0; i < 8; i++) begin
      check("small rx_ready after overflow", {63'd0, s_rx_ready}, 64'd0);
      tick();
    end
    drive(1'b1, 1'b0, 8'd0);

    // Halt word at the last address wins over overflow
    w = {rand_word(), rand_word(), rand_word(), HALT_WORD_DEFAULT};
    run_load(1'b1, w, 2, 1'b0, 1'b0);

    // Checksum stream: good trailer, then a corrupted one
    w = {32'h0102_0304, HALT_WORD_DEFAULT};
    run_load(1'b0, w, 0, 1'b0, 1'b0);
    run_load(1'b0, w, 1, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
